// File: rtl/enet_pkg.sv
// Shared constants for the Ethernet Wishbone port: FSM encodings, header size
// and default buffer geometry.
package enet_pkg;

    localparam int ETH_HDR_BYTES = 14;

    localparam int DEF_TX_WORDS  = 32;
    localparam int DEF_RX_WORDS  = 32;
    localparam int DEF_MIN_WORDS = 30;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_FILL  = 2'd1;
    localparam logic [1:0] T_SEND  = 2'd2;

    localparam logic [1:0] R_RECV  = 2'd0;
    localparam logic [1:0] R_FULL  = 2'd1;
    localparam logic [1:0] R_DRAIN = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/enet_word_ram.sv
// 16-bit word buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module enet_word_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/enet_wb_port.sv
// Wishbone word port between a CPU and a byte-wide MAC: a TX frame buffer that
// pads and serialises frames, and an RX buffer that strips the header and packs bytes.
module enet_wb_port
    import enet_pkg::*;
#(
    parameter int TX_WORDS  = DEF_TX_WORDS,
    parameter int RX_WORDS  = DEF_RX_WORDS,
    parameter int MIN_WORDS = DEF_MIN_WORDS
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_irq_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        tx_last_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic        rx_err_i,
    output logic [7:0]  rx_drop_cnt_o
);

    localparam int TX_PW = $clog2(TX_WORDS + 1);
    localparam int TX_AW = $clog2(TX_WORDS);
    localparam int TX_BW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_WORDS + 1);
    localparam int RX_AW = $clog2(RX_WORDS);
    localparam int RX_CW = RX_PW + 1;

    // Byte streams: a byte moves on a rising edge where valid & ready are both
    // high; valid, data and last stay stable until that edge. The RX side has no
    // backpressure, so every rx_valid_i cycle is a transfer.
    logic wb_req, wr_req, rd_req;

    assign wb_req = wb_cyc_i & wb_stb_i;
    assign wr_req = wb_req & wb_we_i;
    assign rd_req = wb_req & ~wb_we_i;

    // ---------------- TX path ----------------
    logic [1:0]       tx_state_q, tx_state_d;
    logic [TX_PW-1:0] tx_wptr_q, tx_wptr_d;
    logic [TX_PW-1:0] tx_len_q, tx_len_d;
    logic [TX_BW-1:0] tx_bptr_q, tx_bptr_d;
    logic [TX_BW-1:0] tx_last_idx;
    logic [TX_PW-1:0] tx_word_idx;
    logic [15:0]      tx_ram_rdata, tx_word;
    logic             tx_ram_we, tx_wr_ack, tx_wr_err;
    logic             tx_sending, tx_is_last;

    assign tx_sending  = (tx_state_q == T_SEND);
    assign tx_last_idx = {tx_len_q, 1'b0} - TX_BW'(1);
    assign tx_is_last  = tx_sending && (tx_bptr_q == tx_last_idx);
    assign tx_word_idx = tx_bptr_q[TX_BW-1:1];
    // Words beyond those written are the zero padding up to MIN_WORDS.
    assign tx_word     = (tx_word_idx < tx_wptr_q) ? tx_ram_rdata : 16'h0000;

    enet_word_ram #(
        .DEPTH (TX_WORDS),
        .AW    (TX_AW)
    ) u_tx_ram (
        .clk   (wb_clk_i),
        .we    (tx_ram_we),
        .waddr (tx_wptr_q[TX_AW-1:0]),
        .wdata (wb_dat_i),
        .raddr (tx_word_idx[TX_AW-1:0]),
        .rdata (tx_ram_rdata)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_wptr_d  = tx_wptr_q;
        tx_len_d   = tx_len_q;
        tx_bptr_d  = tx_bptr_q;
        tx_ram_we  = 1'b0;
        tx_wr_ack  = 1'b0;
        tx_wr_err  = 1'b0;
        case (tx_state_q)
            T_IDLE, T_FILL: begin
                if (wr_req) begin
                    if (tx_wptr_q == TX_PW'(TX_WORDS)) begin
                        tx_wr_err  = 1'b1;
                        tx_wptr_d  = '0;
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_ram_we  = 1'b1;
                        tx_wr_ack  = 1'b1;
                        tx_wptr_d  = tx_wptr_q + TX_PW'(1);
                        tx_state_d = T_FILL;
                    end
                end else if ((tx_state_q == T_FILL) && !wb_cyc_i) begin
                    tx_len_d   = (tx_wptr_q < TX_PW'(MIN_WORDS)) ? TX_PW'(MIN_WORDS) : tx_wptr_q;
                    tx_bptr_d  = '0;
                    tx_state_d = T_SEND;
                end
            end
            T_SEND: begin
                tx_wr_err = wr_req;
                if (tx_ready_i) begin
                    if (tx_is_last) begin
                        tx_wptr_d  = '0;
                        tx_bptr_d  = '0;
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_bptr_d = tx_bptr_q + TX_BW'(1);
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tx_state_q <= T_IDLE;
            tx_wptr_q  <= '0;
            tx_len_q   <= '0;
            tx_bptr_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_len_q   <= tx_len_d;
            tx_bptr_q  <= tx_bptr_d;
        end
    end

    // ---------------- RX path ----------------
    logic [1:0]       rx_state_q, rx_state_d;
    logic [3:0]       rx_hdr_q, rx_hdr_d;
    logic [RX_CW-1:0] rx_pcnt_q, rx_pcnt_d, rx_pcnt_inc;
    logic             rx_ovf_q, rx_ovf_d;
    logic             rx_skip_q, rx_skip_d;
    logic [RX_PW-1:0] rx_len_q, rx_len_d;
    logic [RX_PW-1:0] rx_rptr_q, rx_rptr_d;
    logic [7:0]       rx_lo_q, rx_lo_d;
    logic [7:0]       rx_drop_q, rx_drop_d;
    logic [RX_PW-1:0] rx_widx, rx_len_new;
    logic [15:0]      rx_ram_wdata, rx_ram_rdata;
    logic             rx_ram_we, rx_rd_ack, rx_rd_err, rx_drop_evt;
    logic             rx_in_hdr, rx_fits, rx_byte_ovf;

    assign rx_widx     = rx_pcnt_q[RX_CW-1:1];
    assign rx_fits     = (rx_widx < RX_PW'(RX_WORDS));
    assign rx_in_hdr   = (rx_hdr_q != 4'(ETH_HDR_BYTES));
    assign rx_pcnt_inc = rx_pcnt_q + RX_CW'(1);
    assign rx_len_new  = rx_in_hdr ? '0 : rx_pcnt_inc[RX_CW-1:1] + RX_PW'(rx_pcnt_inc[0]);
    assign rx_byte_ovf = !rx_in_hdr && !rx_fits;

    enet_word_ram #(
        .DEPTH (RX_WORDS),
        .AW    (RX_AW)
    ) u_rx_ram (
        .clk   (wb_clk_i),
        .we    (rx_ram_we),
        .waddr (rx_widx[RX_AW-1:0]),
        .wdata (rx_ram_wdata),
        .raddr (rx_rptr_q[RX_AW-1:0]),
        .rdata (rx_ram_rdata)
    );

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_hdr_d     = rx_hdr_q;
        rx_pcnt_d    = rx_pcnt_q;
        rx_ovf_d     = rx_ovf_q;
        rx_skip_d    = rx_skip_q;
        rx_len_d     = rx_len_q;
        rx_rptr_d    = rx_rptr_q;
        rx_lo_d      = rx_lo_q;
        rx_ram_we    = 1'b0;
        rx_ram_wdata = 16'h0000;
        rx_rd_ack    = 1'b0;
        rx_rd_err    = 1'b0;
        rx_drop_evt  = 1'b0;
        case (rx_state_q)
            R_RECV: begin
                rx_rd_err = rd_req;
                if (rx_valid_i && rx_skip_q) begin
                    // Tail of a frame that began while the buffer was still held.
                    if (rx_last_i) begin
                        rx_drop_evt = 1'b1;
                        rx_skip_d   = 1'b0;
                    end
                end else if (rx_valid_i) begin
                    if (rx_in_hdr) begin
                        rx_hdr_d = rx_hdr_q + 4'd1;
                    end else if (rx_fits) begin
                        // Even payload byte writes {00,b}; the odd one overwrites the high half.
                        rx_ram_we    = 1'b1;
                        rx_ram_wdata = rx_pcnt_q[0] ? {rx_data_i, rx_lo_q} : {8'h00, rx_data_i};
                        rx_lo_d      = rx_data_i;
                        rx_pcnt_d    = rx_pcnt_inc;
                    end else begin
                        rx_ovf_d = 1'b1;
                    end
                    if (rx_last_i) begin
                        if (rx_err_i || rx_ovf_q || rx_byte_ovf) begin
                            rx_drop_evt = 1'b1;
                        end else begin
                            rx_len_d   = rx_len_new;
                            rx_rptr_d  = '0;
                            rx_state_d = R_FULL;
                        end
                        rx_hdr_d  = '0;
                        rx_pcnt_d = '0;
                        rx_ovf_d  = 1'b0;
                    end
                end
            end
            R_FULL, R_DRAIN: begin
                if (rx_valid_i) begin
                    rx_drop_evt = rx_last_i;
                    rx_skip_d   = ~rx_last_i;
                end
                if (rd_req) begin
                    if (rx_rptr_q == rx_len_q) begin
                        rx_rd_err  = 1'b1;
                        rx_rptr_d  = '0;
                        rx_len_d   = '0;
                        rx_state_d = R_RECV;
                    end else begin
                        rx_rd_ack  = 1'b1;
                        rx_rptr_d  = rx_rptr_q + RX_PW'(1);
                        rx_state_d = R_DRAIN;
                    end
                end
            end
            default: rx_state_d = R_RECV;
        endcase
        rx_drop_d = rx_drop_evt ? sat_inc8(rx_drop_q) : rx_drop_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rx_state_q <= R_RECV;
            rx_hdr_q   <= '0;
            rx_pcnt_q  <= '0;
            rx_ovf_q   <= 1'b0;
            rx_skip_q  <= 1'b0;
            rx_len_q   <= '0;
            rx_rptr_q  <= '0;
            rx_lo_q    <= '0;
            rx_drop_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_hdr_q   <= rx_hdr_d;
            rx_pcnt_q  <= rx_pcnt_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_skip_q  <= rx_skip_d;
            rx_len_q   <= rx_len_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_lo_q    <= rx_lo_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

    // ---------------- Outputs ----------------
    // Bus responses are held low while reset is asserted, even with a live strobe.
    assign wb_ack_o      = wb_rst_n_i & (tx_wr_ack | rx_rd_ack);
    assign wb_err_o      = wb_rst_n_i & (tx_wr_err | rx_rd_err);
    assign wb_dat_o      = rx_rd_ack ? rx_ram_rdata : 16'h0000;
    assign wb_irq_o      = (rx_state_q == R_FULL) || (rx_state_q == R_DRAIN);
    assign tx_valid_o    = tx_sending;
    assign tx_last_o     = tx_is_last;
    assign tx_data_o     = tx_sending ? (tx_bptr_q[0] ? tx_word[7:0] : tx_word[15:8]) : 8'h00;
    assign rx_drop_cnt_o = rx_drop_q;

endmodule

// File: tb/tb_enet_wb_port.sv
// Directed-plus-random bench for enet_wb_port with a frame-level reference model.
module tb_enet_wb_port;

  localparam int TXW  = 32;
  localparam int RXW  = 32;
  localparam int MINW = 30;
  localparam int HDR  = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [15:0] wb_dat_w = '0;
  logic [15:0] wb_dat_r;
  logic        wb_ack, wb_err, wb_irq;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_last = 1'b0, rx_err = 1'b0;
  logic [7:0]  rx_drop;

  always #5 clk = ~clk;

  enet_wb_port #(.TX_WORDS(TXW), .RX_WORDS(RXW), .MIN_WORDS(MINW)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_irq_o(wb_irq),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_last_o(tx_last), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_err_i(rx_err),
    .rx_drop_cnt_o(rx_drop)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] tx_words_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  tx_got_q[$];
  int          tx_last_pos;
  logic [7:0]  rx_frame_q[$];
  logic [15:0] exp_q[$];
  bit          rx_busy_m = 1'b0;
  int          drop_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [15:0] dat,
                           output logic ack, output logic err, output logic [15:0] rdat);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_dat_w = dat;
    #1;
    ack = wb_ack; err = wb_err; rdat = wb_dat_r;
    @(negedge clk);
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_release();
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic tx_write_words(input int n, input bit incr);
    logic a, e;
    logic [15:0] r, w;
    int acks = 0, errs = 0;
    tx_words_q.delete();
    for (int i = 0; i < n; i++) begin
      w = incr ? 16'(i + 1) : 16'($urandom);
      tx_words_q.push_back(w);
      wb_access(1'b1, w, a, e, r);
      acks += int'(a);
      errs += int'(e);
    end
    check("tx_write_acks", acks, (n <= TXW) ? n : TXW);
    check("tx_write_errs", errs, (n <= TXW) ? 0 : n - TXW);
  endtask

  // Frame on the wire: written words, zero-padded to the minimum, high byte first.
  function automatic void tx_model();
    int nw;
    logic [15:0] w;
    tx_exp_q.delete();
    if (tx_words_q.size() > TXW) return;
    nw = (tx_words_q.size() < MINW) ? MINW : tx_words_q.size();
    for (int i = 0; i < nw; i++) begin
      w = (i < tx_words_q.size()) ? tx_words_q[i] : 16'h0000;
      tx_exp_q.push_back(w[15:8]);
      tx_exp_q.push_back(w[7:0]);
    end
  endfunction

  task automatic collect_tx(input int budget, input bit rnd);
    int  cycles = 0;
    bit  done = 1'b0;
    tx_got_q.delete();
    tx_last_pos = -1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (tx_valid && tx_ready) begin
        tx_got_q.push_back(tx_data);
        if (tx_last) begin
          tx_last_pos = tx_got_q.size() - 1;
          done = 1'b1;
        end
      end
      cycles++;
    end
    check("tx_frame_done_in_budget", done, 1'b1);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic compare_tx(input string tag);
    int n;
    check({tag, "_len"}, tx_got_q.size(), tx_exp_q.size());
    n = (tx_got_q.size() < tx_exp_q.size()) ? tx_got_q.size() : tx_exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), tx_got_q[i], tx_exp_q[i]);
    check({tag, "_last_pos"}, tx_last_pos, tx_exp_q.size() - 1);
  endtask

  function automatic void build_frame(input int len);
    rx_frame_q.delete();
    for (int i = 0; i < len; i++) rx_frame_q.push_back(8'($urandom));
  endfunction

  task automatic rx_send(input bit err, input int stop_at);
    int n = rx_frame_q.size();
    for (int i = 0; i < stop_at; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = rx_frame_q[i];
      rx_last  = (i == n - 1);
      rx_err   = err && (i == n - 1);
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
  endtask

  // Accepted frame: payload after the header, packed little-endian into words.
  function automatic void rx_model(input bit err);
    int pay = (rx_frame_q.size() > HDR) ? rx_frame_q.size() - HDR : 0;
    logic [7:0] hi;
    if (rx_busy_m || err || pay > 2 * RXW) begin
      if (drop_m < 255) drop_m++;
      return;
    end
    exp_q.delete();
    for (int i = 0; i < pay; i += 2) begin
      hi = (i + 1 < pay) ? rx_frame_q[HDR + i + 1] : 8'h00;
      exp_q.push_back({hi, rx_frame_q[HDR + i]});
    end
    rx_busy_m = 1'b1;
  endfunction

  task automatic rx_read_all(input string tag);
    logic a, e;
    logic [15:0] r;
    int acks = 0;
    #1;
    check({tag, "_irq_set"}, wb_irq, rx_busy_m);
    for (int i = 0; i < exp_q.size(); i++) begin
      wb_access(1'b0, 16'h0000, a, e, r);
      acks += int'(a);
      check($sformatf("%s_word%0d", tag, i), r, exp_q[i]);
    end
    check({tag, "_acks"}, acks, exp_q.size());
    wb_access(1'b0, 16'h0000, a, e, r);
    check({tag, "_end_err"}, e, 1'b1);
    check({tag, "_end_ack"}, a, 1'b0);
    wb_release();
    rx_busy_m = 1'b0;
    #1;
    check({tag, "_irq_clr"}, wb_irq, rx_busy_m);
  endtask

  initial begin
    logic a, e;
    logic [15:0] r;
    bit seen;

    // Reset with a live read strobe: everything quiet.
    wb_cyc = 1'b1; wb_stb = 1'b1;
    #2;
    check("rst_ack", wb_ack, 1'b0);
    check("rst_err", wb_err, 1'b0);
    check("rst_irq", wb_irq, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_last", tx_last, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_drop", rx_drop, 8'h00);
    check("rst_dat_o", wb_dat_r, 16'h0000);
    wb_release();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Incrementing 21-word frame, padded to 60 bytes.
    tx_write_words(21, 1'b1);
    wb_release();
    tx_model();
    collect_tx(400, 1'b0);
    compare_tx("tx_incr");

    // Random frames with random MAC backpressure, including the full 32 words.
    for (int k = 0; k < 3; k++) begin
      tx_write_words((k == 2) ? TXW : $urandom_range(1, TXW), 1'b0);
      wb_release();
      tx_model();
      collect_tx(800, 1'b1);
      compare_tx($sformatf("tx_rand%0d", k));
    end

    // 33 words: overflow refused, nothing sent.
    tx_write_words(TXW + 1, 1'b0);
    wb_release();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (tx_valid) seen = 1'b1;
    end
    check("tx_ovf_silent", seen, 1'b0);

    // Write while sending is refused and leaves the frame untouched.
    tx_write_words(5, 1'b0);
    wb_release();
    repeat (3) @(negedge clk);
    #1;
    check("tx_send_valid", tx_valid, 1'b1);
    wb_access(1'b1, 16'hDEAD, a, e, r);
    check("tx_send_wr_err", e, 1'b1);
    check("tx_send_wr_ack", a, 1'b0);
    wb_release();
    tx_model();
    collect_tx(400, 1'b1);
    compare_tx("tx_after_refused");

    // Read with no frame held.
    wb_access(1'b0, 16'h0000, a, e, r);
    check("rx_idle_rd_err", e, 1'b1);
    check("rx_idle_rd_ack", a, 1'b0);
    wb_release();

    // 42-byte ARP frame, payload starting 00 01.
    build_frame(42);
    rx_frame_q[14] = 8'h00;
    rx_frame_q[15] = 8'h01;
    rx_send(1'b0, 42);
    rx_model(1'b0);
    rx_read_all("rx_arp");

    // Errored frame dropped; frame arriving while full dropped; held frame intact.
    build_frame(30);
    rx_send(1'b1, 30);
    rx_model(1'b1);
    #1;
    check("rx_err_irq", wb_irq, rx_busy_m);
    check("rx_err_drop", rx_drop, drop_m);
    build_frame(21);
    rx_send(1'b0, 21);
    rx_model(1'b0);
    begin
      logic [15:0] held_q[$];
      held_q = exp_q;
      build_frame(40);
      rx_send(1'b0, 40);
      rx_model(1'b0);
      exp_q = held_q;
    end
    #1;
    check("rx_full_drop", rx_drop, drop_m);
    rx_read_all("rx_odd");

    // Buffer boundary: 64 payload bytes fit, 65 do not.
    build_frame(HDR + 2 * RXW);
    rx_send(1'b0, rx_frame_q.size());
    rx_model(1'b0);
    rx_read_all("rx_max");
    build_frame(HDR + 2 * RXW + 1);
    rx_send(1'b0, rx_frame_q.size());
    rx_model(1'b0);
    #1;
    check("rx_ovf_irq", wb_irq, rx_busy_m);
    check("rx_ovf_drop", rx_drop, drop_m);

    // TX send and RX receive at the same time.
    tx_write_words(12, 1'b0);
    wb_release();
    tx_model();
    build_frame(60);
    rx_model(1'b0);
    fork
      collect_tx(800, 1'b1);
      rx_send(1'b0, 60);
    join
    compare_tx("tx_concurrent");
    rx_read_all("rx_concurrent");

    // Reset mid-send and mid-receive.
    tx_write_words(25, 1'b0);
    wb_release();
    tx_ready = 1'b1;
    build_frame(50);
    rx_send(1'b0, 20);
    #1;
    check("mid_tx_valid", tx_valid, 1'b1);
    check("mid_drop", rx_drop, drop_m);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_last", tx_last, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_irq", wb_irq, 1'b0);
    check("mid_rst_drop", rx_drop, 8'h00);
    drop_m = 0;
    rx_busy_m = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tx_write_words(8, 1'b0);
    wb_release();
    tx_model();
    collect_tx(400, 1'b1);
    compare_tx("tx_post_rst");
    build_frame(33);
    rx_send(1'b0, 33);
    rx_model(1'b0);
    rx_read_all("rx_post_rst");
    check("post_rst_drop", rx_drop, drop_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/enet_wb_port.md
ENET_WB_PORT -- requirements
Module: enet_wb_port

Interface
REQ-001 SHALL have parameter TX_WORDS, default 32, TX buffer depth in 16-bit words.
REQ-002 SHALL have parameter RX_WORDS, default 32, RX buffer depth in 16-bit words.
REQ-003 SHALL have parameter MIN_WORDS, default 30, minimum TX frame length in words (60 bytes, pre-FCS).
REQ-004 Ports (clock and reset first); one clock, reset asynchronous and active-low:
  wb_clk_i  in  1  sole clock, all logic rising-edge
  wb_rst_n_i  in  1  asynchronous active-low reset
  wb_cyc_i  in  1  Wishbone cycle
  wb_stb_i  in  1  Wishbone strobe
  wb_we_i  in  1  1 = write TX word, 0 = read RX word
  wb_dat_i  in  16  TX word
  wb_dat_o  out  16  RX word
  wb_ack_o  out  1  word accepted/delivered
  wb_err_o  out  1  end-of-frame on read, or refused access
  wb_irq_o  out  1  RX frame available
  tx_data_o  out  8  byte to MAC
  tx_valid_o  out  1  tx_data_o valid
  tx_last_o  out  1  final byte of frame
  tx_ready_i  in  1  MAC accepts byte
  rx_data_i  in  8  byte from MAC
  rx_valid_i  in  1  rx_data_i valid
  rx_last_i  in  1  final byte of frame
  rx_err_i  in  1  frame bad (CRC/PHY), qualified by rx_last_i
  rx_drop_cnt_o  out  8  dropped RX frames, saturating

Function
REQ-005 TX FSM SHALL have states T_IDLE, T_FILL, T_SEND.
REQ-006 T_IDLE/T_FILL: cyc&stb&we SHALL store wb_dat_i at write pointer and assert wb_ack_o same cycle (combinational, one per stb cycle); T_IDLE->T_FILL on first write.
REQ-007 Write when pointer == TX_WORDS SHALL assert wb_err_o, discard frame, return to T_IDLE.
REQ-008 T_FILL with wb_cyc_i low SHALL commit frame: length = max(words written, MIN_WORDS), padding words zero; ->T_SEND.
REQ-009 T_SEND SHALL emit each word high byte first, byte advance only on tx_valid_o&tx_ready_i, tx_last_o on final byte; ->T_IDLE after final handshake.
REQ-010 Write in T_SEND SHALL assert wb_err_o, no ack, no store.
REQ-011 RX FSM SHALL have states R_RECV, R_FULL, R_DRAIN.
REQ-012 R_RECV SHALL discard first 14 bytes (Ethernet header), pack following bytes into words, first byte in [7:0], second in [15:8]; odd trailing byte zero-padded in [15:8].
REQ-013 rx_last_i without rx_err_i SHALL latch word length, ->R_FULL; rx_err_i or payload exceeding RX_WORDS SHALL discard, stay R_RECV, increment rx_drop_cnt_o.
REQ-014 wb_irq_o SHALL equal (state == R_FULL | state == R_DRAIN).
REQ-015 Read in R_FULL/R_DRAIN SHALL return word at read pointer with wb_ack_o same cycle, advance pointer; R_FULL->R_DRAIN on first read.
REQ-016 Read with pointer == length SHALL assert wb_err_o one cycle, no ack, release buffer, ->R_RECV.
REQ-017 Read in R_RECV SHALL assert wb_err_o, no ack.
REQ-018 Bytes arriving while R_FULL/R_DRAIN SHALL be ignored; their rx_last_i SHALL increment rx_drop_cnt_o.
REQ-019 wb_ack_o and wb_err_o SHALL never be high together; both low when cyc&stb low.
REQ-020 TX and RX paths SHALL be independent; simultaneous TX send and RX receive SHALL both proceed.

Reset
REQ-021 wb_rst_n_i low SHALL asynchronously force T_IDLE, R_RECV, all pointers/lengths 0, rx_drop_cnt_o 0, all outputs 0; an in-flight TX frame SHALL be abandoned without tx_last_o.
REQ-022 Buffer RAM contents SHALL not be reset.

Structure
REQ-023 Shared package enet_pkg SHALL hold state encodings, ETH_HDR_BYTES = 14 and default depth constants.
REQ-024 Both buffers SHALL be instances of one sub-module enet_word_ram (1 write, 1 async read port, 16-bit).

Verification
REQ-025 Write 21 words 0x0001..0x0015, drop cyc -> 60 bytes: 00 01 00 02 .. 00 15 then 18 zero bytes, tx_last_o on byte 60.
REQ-026 tx_ready_i toggled 50% during send -> identical byte order, no byte skipped or duplicated.
REQ-027 RX 42-byte ARP frame, bytes 14..15 = 00 01 -> first read 0x0100; 14 reads acked; 15th read err, irq drops.
REQ-028 RX frame with rx_err_i -> no irq, rx_drop_cnt_o = 1; second frame during R_FULL -> rx_drop_cnt_o = 2, first frame intact.
REQ-029 Write 33 words -> 33rd gets wb_err_o, no TX output; write during T_SEND -> wb_err_o.
REQ-030 Reset asserted mid-send and mid-receive -> outputs 0 immediately, next frames handled normally.
